// File: rtl/can_bit_destuffer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : can_bit_destuffer_if
// Purpose  : Sampler/decoder-facing bundle of the CAN bit destuffer.
//            CAN_DESTUFF_COUNT_EN adds the stuffCount signal.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface can_bit_destuffer_if;
  logic       samplePoint;
  logic       canRX;
  logic       frameStart;
  logic       enable;
  logic       bitOut;
  logic       bitValid;
  logic       stuffBit;
  logic       stuffErro;
`ifdef CAN_DESTUFF_COUNT_EN
  logic [3:0] stuffCount;
`endif

  modport master (
    output samplePoint, canRX, frameStart, enable,
`ifdef CAN_DESTUFF_COUNT_EN
    input  stuffCount,
`endif
    input  bitOut, bitValid, stuffBit, stuffErro
  );

  modport slave (
    input  samplePoint, canRX, frameStart, enable,
`ifdef CAN_DESTUFF_COUNT_EN
    output stuffCount,
`endif
    output bitOut, bitValid, stuffBit, stuffErro
  );
endinterface
`default_nettype wire

// File: rtl/can_bit_destuffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : can_bit_destuffer
// Purpose  : Removes CAN stuff bits at each sample point and flags stuff errors.
//            CAN_DESTUFF_COUNT_EN adds a saturating per-frame stuff-bit count.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module can_bit_destuffer #(
  parameter int RUN_LENGTH = 5,
  parameter int CNT_W      = 3
) (
  input  wire logic          clock,
  input  wire logic          reset,
  can_bit_destuffer_if.slave bus
);

  localparam logic [CNT_W-1:0] c_RUN_MAX = CNT_W'(RUN_LENGTH);
  localparam logic [CNT_W-1:0] c_RUN_ONE = CNT_W'(1);

  logic             bitOut_q,    bitOut_d;
  logic             bitValid_q,  bitValid_d;
  logic             stuffBit_q,  stuffBit_d;
  logic             stuffErro_q, stuffErro_d;
  logic             lastBit_q,   lastBit_d;
  logic [CNT_W-1:0] runLen_q,    runLen_d;
`ifdef CAN_DESTUFF_COUNT_EN
  logic [3:0]       count_q,     count_d;
`endif

  always_comb begin
    bitOut_d    = bitOut_q;
    bitValid_d  = 1'b0;
    stuffBit_d  = 1'b0;
    stuffErro_d = stuffErro_q;
    lastBit_d   = lastBit_q;
    runLen_d    = runLen_q;
`ifdef CAN_DESTUFF_COUNT_EN
    count_d     = count_q;
`endif
    if (bus.samplePoint) begin
      if (bus.frameStart) begin
        // SOF is a data bit and also opens the first run
        stuffErro_d = 1'b1;
        lastBit_d   = bus.canRX;
        runLen_d    = c_RUN_ONE;
        bitOut_d    = bus.canRX;
        bitValid_d  = 1'b1;
`ifdef CAN_DESTUFF_COUNT_EN
        count_d     = 4'd0;
`endif
      end else if (!bus.enable) begin
        runLen_d  = '0;
        lastBit_d = 1'b1;
      end else if (stuffErro_q) begin
        if (runLen_q == c_RUN_MAX) begin
          if (bus.canRX != lastBit_q) begin
            stuffBit_d = 1'b1;
            lastBit_d  = bus.canRX;
            runLen_d   = c_RUN_ONE;
`ifdef CAN_DESTUFF_COUNT_EN
            if (count_q != 4'hF) begin
              count_d = count_q + 4'd1;
            end
`endif
          end else begin
            stuffErro_d = 1'b0;
          end
        end else begin
          bitOut_d   = bus.canRX;
          bitValid_d = 1'b1;
          if (bus.canRX == lastBit_q) begin
            runLen_d = runLen_q + c_RUN_ONE;
          end else begin
            runLen_d  = c_RUN_ONE;
            lastBit_d = bus.canRX;
          end
        end
      end
      // stuffErro low with enable high: locked until frameStart or reset
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bitOut_q    <= 1'b1;
      bitValid_q  <= 1'b0;
      stuffBit_q  <= 1'b0;
      stuffErro_q <= 1'b1;
      lastBit_q   <= 1'b1;
      runLen_q    <= '0;
`ifdef CAN_DESTUFF_COUNT_EN
      count_q     <= 4'd0;
`endif
    end else begin
      bitOut_q    <= bitOut_d;
      bitValid_q  <= bitValid_d;
      stuffBit_q  <= stuffBit_d;
      stuffErro_q <= stuffErro_d;
      lastBit_q   <= lastBit_d;
      runLen_q    <= runLen_d;
`ifdef CAN_DESTUFF_COUNT_EN
      count_q     <= count_d;
`endif
    end
  end

  assign bus.bitOut    = bitOut_q;
  assign bus.bitValid  = bitValid_q;
  assign bus.stuffBit  = stuffBit_q;
  assign bus.stuffErro = stuffErro_q;
`ifdef CAN_DESTUFF_COUNT_EN
  assign bus.stuffCount = count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_can_bit_destuffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_can_bit_destuffer
// Purpose  : Directed self-checking bench for can_bit_destuffer.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_can_bit_destuffer;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  can_bit_destuffer_if ifc ();

  can_bit_destuffer #(.RUN_LENGTH(5), .CNT_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  int   total = 0;
  int   bad   = 0;
  int   nv    = 0;
  int   ns    = 0;
  int   nboth = 0;
  logic vbits[$];
  int   bv, bs;
  logic [31:0] seq;

  always @(negedge clock) begin
    if (ifc.bitValid === 1'b1) begin
      nv++;
      vbits.push_back(ifc.bitOut);
    end
    if (ifc.stuffBit === 1'b1) ns++;
    if (ifc.bitValid === 1'b1 && ifc.stuffBit === 1'b1) nboth++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic fs, input logic en, input logic rx);
    @(negedge clock);
    ifc.samplePoint = 1'b1;
    ifc.frameStart  = fs;
    ifc.enable      = en;
    ifc.canRX       = rx;
    @(negedge clock);
    ifc.samplePoint = 1'b0;
    ifc.frameStart  = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset           = 1'b1;
    ifc.samplePoint = 1'b0;
    ifc.frameStart  = 1'b0;
    ifc.enable      = 1'b0;
    ifc.canRX       = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_bitOut",    ifc.bitOut,    1);
    chk("rst_bitValid",  ifc.bitValid,  0);
    chk("rst_stuffBit",  ifc.stuffBit,  0);
    chk("rst_stuffErro", ifc.stuffErro, 1);
`ifdef CAN_DESTUFF_COUNT_EN
    chk("rst_count",     ifc.stuffCount, 0);
`endif
    reset = 1'b0;

    // SOF 0, 0000, stuff 1, data 1 0
    bv = nv; bs = ns;
    step(1, 1, 0);
    chk("t1_sof_valid", ifc.bitValid, 1);
    chk("t1_sof_bit",   ifc.bitOut,   0);
    repeat (4) step(0, 1, 0);
    step(0, 1, 1);
    chk("t1_stuff_pulse", ifc.stuffBit, 1);
    chk("t1_stuff_novld", ifc.bitValid, 0);
    chk("t1_stuff_hold",  ifc.bitOut,   0);
    step(0, 1, 1);
    step(0, 1, 0);
    chk("t1_nvalid", nv - bv, 7);
    seq = '0;
    for (int i = 0; i < 7; i++) seq = {seq[30:0], vbits[bv + i]};
    chk("t1_bits",   seq, 32'b0000010);
    chk("t1_nstuff", ns - bs, 1);
    chk("t1_err",    ifc.stuffErro, 1);
`ifdef CAN_DESTUFF_COUNT_EN
    chk("t1_count",  ifc.stuffCount, 1);
`endif

    // six identical 0s (SOF included) -> stuff error, then locked
    bv = nv; bs = ns;
    step(1, 1, 0);
    repeat (4) step(0, 1, 0);
    chk("t2_err_at5", ifc.stuffErro, 1);
    step(0, 1, 0);
    chk("t2_err_at6", ifc.stuffErro, 0);
    chk("t2_novld6",  ifc.bitValid,  0);
    step(0, 1, 0);
    step(0, 1, 1);
    chk("t2_nvalid",  nv - bv, 5);
    chk("t2_nstuff",  ns - bs, 0);
    step(0, 0, 0);
    chk("t2_err_hold_dis", ifc.stuffErro, 0);
    step(1, 1, 1);
    chk("t2_err_clear", ifc.stuffErro, 1);
    chk("t2_sof_valid", ifc.bitValid,  1);
    chk("t2_sof_bit",   ifc.bitOut,    1);

    // stuff bits opening new runs: three stuffs, thirteen data bits
    bv = nv; bs = ns;
    step(1, 1, 1);
    repeat (4) step(0, 1, 1);
    step(0, 1, 0);
    chk("t3_stuff1", ifc.stuffBit, 1);
    repeat (4) step(0, 1, 0);
    step(0, 1, 1);
    chk("t3_stuff2", ifc.stuffBit, 1);
    repeat (4) step(0, 1, 1);
    step(0, 1, 0);
    chk("t3_stuff3", ifc.stuffBit, 1);
    chk("t3_nstuff", ns - bs, 3);
    chk("t3_nvalid", nv - bv, 13);
    chk("t3_err",    ifc.stuffErro, 1);
    chk("t3_both",   nboth, 0);
`ifdef CAN_DESTUFF_COUNT_EN
    chk("t3_count3", ifc.stuffCount, 3);
    step(1, 1, 0);
    chk("t3_count_clr", ifc.stuffCount, 0);
`endif

    // enable low ignores bits; tracking restarts from runLen=0, lastBit=1
    bv = nv; bs = ns;
    repeat (10) step(0, 0, 0);
    chk("t4_dis_nvalid", nv - bv, 0);
    chk("t4_dis_nstuff", ns - bs, 0);
    chk("t4_dis_err",    ifc.stuffErro, 1);
    repeat (5) step(0, 1, 0);
    chk("t4_nvalid", nv - bv, 5);
    step(0, 1, 1);
    chk("t4_stuff",  ifc.stuffBit, 1);
    chk("t4_err",    ifc.stuffErro, 1);

    // asynchronous reset between sample points with runLen=4
    step(1, 1, 0);
    repeat (3) step(0, 1, 0);
    chk("t5_pre_valid", ifc.bitValid, 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_bitOut",   ifc.bitOut,    1);
    chk("t5_rst_bitValid", ifc.bitValid,  0);
    chk("t5_rst_err",      ifc.stuffErro, 1);
    @(negedge clock);
    reset = 1'b0;
    bv = nv;
    step(1, 1, 0);
    repeat (4) step(0, 1, 0);
    chk("t5_post_err",    ifc.stuffErro, 1);
    chk("t5_post_nvalid", nv - bv, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
